hack_rom_loader: RTL

//   Upstream stage of the Hack CPU. Receives a program image over a byte-stream handshake.

---
 rtl/hack_rom_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hack_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : hack_rom_loader
//  Purpose  : Front end of the Hack CPU. This block receives a program image
//             as a big-endian byte stream:
//                LEN_HI LEN_LO {W_HI W_LO} x N CK_HI CK_LO
//             It writes the words into an internal instruction ROM and serves
//             them to the CPU by program counter. The CPU is held in reset
//             until a complete image with a matching 16-bit checksum has been
//             loaded.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             load_start      - 1-cycle pulse, begins or restarts a load
//             in_data/in_valid/in_ready - byte stream handshake
//             pc              - CPU program counter
//             instruction     - ROM word at pc (combinational)
//             cpu_reset       - registered reset to the CPU
//             load_busy       - frame reception in progress
//             load_done       - sticky, last load good
//             load_error      - sticky, last load bad
//             words_loaded    - data words written by the current/last load
//  Revision : 1.0  initial release
// ============================================================================
module hack_rom_loader #(
   parameter int ADDR_W = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] pc,
   output logic [15:0] instruction,
   output logic        cpu_reset,
   output logic        load_busy,
   output logic        load_done,
   output logic        load_error,
   output logic [15:0] words_loaded
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LEN_HI = 4'd1,
      S_LEN_LO = 4'd2,
      S_DAT_HI = 4'd3,
      S_DAT_LO = 4'd4,
      S_CK_HI  = 4'd5,
      S_CK_LO  = 4'd6,
      S_DONE   = 4'd7,
      S_ERROR  = 4'd8
   } state_t;

   state_t        state;
   logic [15:0]   len;        // word count N of the frame in progress
   logic [15:0]   sum;        // running checksum, wraps mod 2**16
   logic [7:0]    hi_byte;    // high byte of the current LEN/word/CK pair

   logic [15:0]   rom [DEPTH];

   logic          accept;
   logic [15:0]   pair_word;
   logic [16:0]   pair_ext;
   logic          rom_we;
   logic          last_word;

   // ------------------------------------------------------------------------
   // Handshake and status decode: a pure function of the state register, so
   // in_ready never depends combinationally on in_valid.
   // ------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      load_busy = 1'b0;
      case (state)
         S_LEN_HI, S_LEN_LO,
         S_DAT_HI, S_DAT_LO,
         S_CK_HI,  S_CK_LO: begin
            in_ready  = 1'b1;
            load_busy = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            load_busy = 1'b0;
         end
      endcase
   end

   assign accept    = in_valid & in_ready;
   assign pair_word = {hi_byte, in_data};
   assign pair_ext  = {1'b0, pair_word};
   assign last_word = ((words_loaded + 16'd1) == len);

   // A restart or reset on the same edge as W_LO discards that word.
   assign rom_we = accept & (state == S_DAT_LO) & ~load_start & ~reset;

   // ------------------------------------------------------------------------
   // Loader FSM with registered status outputs.
   // load_start has priority over a byte accepted on the same edge: the
   // frame is restarted and that byte is dropped.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cpu_reset    <= 1'b1;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
         words_loaded <= 16'd0;
         sum          <= 16'd0;
         len          <= 16'd0;
         hi_byte      <= 8'd0;
      end else begin
         // Follows the state by one edge, so the CPU leaves reset on the
         // edge after DONE is entered and its first fetch sees rom[0].
         cpu_reset <= (state != S_DONE);

         if (load_start) begin
            state        <= S_LEN_HI;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= 16'd0;
            sum          <= 16'd0;
         end else if (accept) begin
            case (state)
               S_LEN_HI: begin
                  hi_byte <= in_data;
                  state   <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  len <= pair_word;
                  if (pair_word == 16'd0) begin
                     state <= S_CK_HI;
                  end else if (pair_ext > 17'(DEPTH)) begin
                     state      <= S_ERROR;
                     load_error <= 1'b1;
                  end else begin
                     state <= S_DAT_HI;
                  end
               end
               S_DAT_HI: begin
                  hi_byte <= in_data;
                  state   <= S_DAT_LO;
               end
               S_DAT_LO: begin
                  words_loaded <= words_loaded + 16'd1;
                  sum          <= sum + pair_word;
                  state        <= last_word ? S_CK_HI : S_DAT_HI;
               end
               S_CK_HI: begin
                  hi_byte <= in_data;
                  state   <= S_CK_LO;
               end
               S_CK_LO: begin
                  if (pair_word == sum) begin
                     state     <= S_DONE;
                     load_done <= 1'b1;
                  end else begin
                     state      <= S_ERROR;
                     load_error <= 1'b1;
                  end
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Instruction ROM: synchronous write, asynchronous read. Contents survive
   // reset and restart; only the words of a new frame are overwritten. A
   // same-cycle read of the address being written sees the old word.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rom_we) begin
         rom[words_loaded[ADDR_W-1:0]] <= pair_word;
      end
   end

   // Addresses above the ROM and any fetch while the CPU is in reset read 0.
   always_comb begin
      instruction = 16'h0000;
      if (!cpu_reset && ((pc >> ADDR_W) == 16'd0)) begin
         instruction = rom[pc[ADDR_W-1:0]];
      end
   end

endmodule
`default_nettype wire
